// File: rtl/ibias_seq_pkg.sv
// Shared types and constants for the current/voltage bias sequencer.
// Holds the 3-bit FSM state encoding (also exported on state_o for debug),
// trim field widths and trim reset values, plus small elaboration helpers.
package ibias_seq_pkg;

  localparam int unsigned StateW     = 3;
  localparam int unsigned TrimIbiasW = 5;
  localparam int unsigned TrimVbiasW = 4;

  // Mid-scale trims so an untrimmed cell sits at nominal bias.
  localparam logic [TrimIbiasW-1:0] TrimIbiasRst = 5'd16;
  localparam logic [TrimVbiasW-1:0] TrimVbiasRst = 4'd8;

  typedef enum logic [StateW-1:0] {
    StOff       = 3'd0,
    StStartup   = 3'd1,
    StWaitValid = 3'd2,
    StSettle    = 3'd3,
    StReady     = 3'd4,
    StError     = 3'd5
  } biasState_e;

  // Largest of three cycle parameters; sizes the shared counter.
  function automatic int unsigned maxOf3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // States in which the bias cell is enabled and following the requests.
  function automatic logic isActive(input biasState_e s);
    return (s == StStartup) || (s == StWaitValid) ||
           (s == StSettle)  || (s == StReady);
  endfunction

endpackage

// File: rtl/ibias_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  - destination clock
//   rst_ni - synchronous active-low reset, both flops clear to 0
//   d_i    - asynchronous input
//   q_o    - synchronized output, two cycles of latency
module ibias_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta <= 1'b0;
      q_o  <= 1'b0;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/ibias_seq_ctrl.sv
// Bias power-up sequencer: kicks the bandgap, waits for its valid flag,
// requires a stable settle window, then flags the bias as ready. Loss of
// valid while ready, or no valid within the timeout, latches a sticky error.
// Ports:
//   clk_i, rst_ni              - clock, synchronous active-low reset
//   req_ibias_i, req_vbias_i   - bias requests
//   trim_load_i                - strobe capturing trim_ibias_i / trim_vbias_i
//   err_clr_i                  - clears the sticky error (ERROR -> OFF)
//   bg_valid_i                 - asynchronous bandgap valid
//   en_ibias_o, en_vbias_o     - registered cell enables
//   bg_startup_o               - bandgap startup kick
//   trim_ibias_o, trim_vbias_o - registered trims
//   bias_ready_o, bias_err_o   - status
//   state_o                    - FSM state for debug
module ibias_seq_ctrl
  import ibias_seq_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = 16,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_ibias_i,
  input  logic                  req_vbias_i,
  input  logic                  trim_load_i,
  input  logic [TrimIbiasW-1:0] trim_ibias_i,
  input  logic [TrimVbiasW-1:0] trim_vbias_i,
  input  logic                  err_clr_i,
  input  logic                  bg_valid_i,
  output logic                  en_ibias_o,
  output logic                  en_vbias_o,
  output logic                  bg_startup_o,
  output logic [TrimIbiasW-1:0] trim_ibias_o,
  output logic [TrimVbiasW-1:0] trim_vbias_o,
  output logic                  bias_ready_o,
  output logic                  bias_err_o,
  output logic [StateW-1:0]     state_o
);

  localparam int unsigned MaxCyc = maxOf3(STARTUP_CYC, SETTLE_CYC, TIMEOUT_CYC);
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  // Reload values: a state loaded with N-1 on entry spends exactly N cycles
  // before its counter hits zero and the exit condition fires.
  localparam logic [CntW-1:0] StartupLoad = CntW'(STARTUP_CYC - 1);
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYC - 1);

  biasState_e            state;
  biasState_e            stateNext;
  logic [CntW-1:0]       cnt;
  logic [CntW-1:0]       cntNext;
  logic                  vld;
  logic                  anyReq;
  logic                  enIbiasNext;
  logic                  enVbiasNext;
  logic                  bgStartupNext;
  logic                  readyNext;
  logic                  errNext;
  logic [TrimIbiasW-1:0] trimIbiasNext;
  logic [TrimVbiasW-1:0] trimVbiasNext;

  // bg_valid_i crosses from the analog domain; only the synced copy is used.
  ibias_sync2 u_bgValidSync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bg_valid_i),
    .q_o    (vld)
  );

  assign anyReq  = req_ibias_i | req_vbias_i;
  assign state_o = state;

  // Next state, shared counter and registered-output next values.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    enIbiasNext   = 1'b0;
    enVbiasNext   = 1'b0;
    bgStartupNext = 1'b0;
    readyNext     = 1'b0;
    errNext       = 1'b0;
    trimIbiasNext = trim_ibias_o;
    trimVbiasNext = trim_vbias_o;

    // Dropping both requests wins over everything except the sticky error.
    unique case (state)
      StOff: begin
        if (anyReq) stateNext = StStartup;
      end
      StStartup: begin
        if (!anyReq)          stateNext = StOff;
        else if (cnt == '0)   stateNext = StWaitValid;
      end
      StWaitValid: begin
        if (!anyReq)          stateNext = StOff;
        else if (vld)         stateNext = StSettle;
        else if (cnt == '0)   stateNext = StError;
      end
      StSettle: begin
        if (!anyReq)          stateNext = StOff;
        else if (!vld)        stateNext = StWaitValid;
        else if (cnt == '0)   stateNext = StReady;
      end
      StReady: begin
        // Loss of valid outranks a trim reload.
        if (!anyReq)          stateNext = StOff;
        else if (!vld)        stateNext = StError;
        else if (trim_load_i) stateNext = StSettle;
      end
      StError: begin
        if (err_clr_i) stateNext = StOff;
      end
      default: stateNext = StOff;
    endcase

    // Counter reloads on every state change, otherwise counts down to zero.
    if (stateNext != state) begin
      case (stateNext)
        StStartup:   cntNext = StartupLoad;
        StWaitValid: cntNext = TimeoutLoad;
        StSettle:    cntNext = SettleLoad;
        default:     cntNext = '0;
      endcase
    end else if (cnt != '0) begin
      cntNext = cnt - CntW'(1);
    end

    // Outputs are decoded from the next state so they align with state_o.
    if (isActive(stateNext)) begin
      enIbiasNext = req_ibias_i;
      enVbiasNext = req_vbias_i;
    end
    bgStartupNext = (stateNext == StStartup);
    readyNext     = (stateNext == StReady);
    errNext       = (stateNext == StError);

    if (trim_load_i) begin
      trimIbiasNext = trim_ibias_i;
      trimVbiasNext = trim_vbias_i;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= StOff;
      cnt          <= '0;
      en_ibias_o   <= 1'b0;
      en_vbias_o   <= 1'b0;
      bg_startup_o <= 1'b0;
      bias_ready_o <= 1'b0;
      bias_err_o   <= 1'b0;
      trim_ibias_o <= TrimIbiasRst;
      trim_vbias_o <= TrimVbiasRst;
    end else begin
      state        <= stateNext;
      cnt          <= cntNext;
      en_ibias_o   <= enIbiasNext;
      en_vbias_o   <= enVbiasNext;
      bg_startup_o <= bgStartupNext;
      bias_ready_o <= readyNext;
      bias_err_o   <= errNext;
      trim_ibias_o <= trimIbiasNext;
      trim_vbias_o <= trimVbiasNext;
    end
  end

endmodule

// File: tb/tb_ibias_seq_ctrl.sv
// Directed bench for ibias_seq_ctrl with default cycle parameters.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_ibias_seq_ctrl;

  localparam logic [2:0] stOff    = 3'd0;
  localparam logic [2:0] stStart  = 3'd1;
  localparam logic [2:0] stWait   = 3'd2;
  localparam logic [2:0] stSettle = 3'd3;
  localparam logic [2:0] stReady  = 3'd4;
  localparam logic [2:0] stError  = 3'd5;

  logic       clk_i;
  logic       rst_ni;
  logic       req_ibias_i;
  logic       req_vbias_i;
  logic       trim_load_i;
  logic [4:0] trim_ibias_i;
  logic [3:0] trim_vbias_i;
  logic       err_clr_i;
  logic       bg_valid_i;
  logic       en_ibias_o;
  logic       en_vbias_o;
  logic       bg_startup_o;
  logic [4:0] trim_ibias_o;
  logic [3:0] trim_vbias_o;
  logic       bias_ready_o;
  logic       bias_err_o;
  logic [2:0] state_o;

  int nCompared;
  int nMismatched;

  // {en_ibias, en_vbias, bg_startup, bias_ready, bias_err}
  wire [4:0] flags = {en_ibias_o, en_vbias_o, bg_startup_o, bias_ready_o, bias_err_o};

  ibias_seq_ctrl #(
    .STARTUP_CYC (16),
    .SETTLE_CYC  (64),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_ibias_i  (req_ibias_i),
    .req_vbias_i  (req_vbias_i),
    .trim_load_i  (trim_load_i),
    .trim_ibias_i (trim_ibias_i),
    .trim_vbias_i (trim_vbias_i),
    .err_clr_i    (err_clr_i),
    .bg_valid_i   (bg_valid_i),
    .en_ibias_o   (en_ibias_o),
    .en_vbias_o   (en_vbias_o),
    .bg_startup_o (bg_startup_o),
    .trim_ibias_o (trim_ibias_o),
    .trim_vbias_o (trim_vbias_o),
    .bias_ready_o (bias_ready_o),
    .bias_err_o   (bias_err_o),
    .state_o      (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Steps until state_o == target; returns maxSteps+1 if it never gets there.
  task automatic waitState(input logic [2:0] target, input int maxSteps, output int steps);
    steps = 0;
    while (steps <= maxSteps) begin
      step();
      steps++;
      if (state_o == target) break;
    end
  endtask

  task automatic applyReset();
    rst_ni = 1'b0; req_ibias_i = 1'b0; req_vbias_i = 1'b0; trim_load_i = 1'b0;
    trim_ibias_i = '0; trim_vbias_i = '0; err_clr_i = 1'b0; bg_valid_i = 1'b0;
    step(); step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    applyReset();
    nCompared++; if (state_o !== stOff) begin nMismatched++; $display("FAIL reset_state: got %0d want %0d", state_o, stOff); end
    nCompared++; if (flags !== 5'b00000) begin nMismatched++; $display("FAIL reset_flags: got %b want 00000", flags); end
    nCompared++; if (trim_ibias_o !== 5'd16 || trim_vbias_o !== 4'd8) begin nMismatched++; $display("FAIL reset_trims: got %0d/%0d want 16/8", trim_ibias_o, trim_vbias_o); end
  endtask

  // req_ibias only; valid arrives 5 cycles into WAIT_VALID.
  task automatic test_ibias_startup();
    int n;
    applyReset();
    req_ibias_i = 1'b1;
    step();
    nCompared++; if (state_o !== stStart) begin nMismatched++; $display("FAIL s1_enter_startup: got %0d want %0d", state_o, stStart); end
    nCompared++; if (flags !== 5'b10100) begin nMismatched++; $display("FAIL s1_startup_flags: got %b want 10100", flags); end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bg_startup_o === 1'b1) n++; else break;
    end
    nCompared++; if (n !== 16) begin nMismatched++; $display("FAIL s1_startup_len: got %0d want 16", n); end
    nCompared++; if (state_o !== stWait) begin nMismatched++; $display("FAIL s1_after_startup: got %0d want %0d", state_o, stWait); end
    for (int i = 0; i < 4; i++) step();
    bg_valid_i = 1'b1;
    waitState(stSettle, 10, n);
    nCompared++; if (n !== 3) begin nMismatched++; $display("FAIL s1_sync_latency: got %0d want 3", n); end
    waitState(stReady, 100, n);
    nCompared++; if (n !== 64) begin nMismatched++; $display("FAIL s1_settle_len: got %0d want 64", n); end
    nCompared++; if (flags !== 5'b10010) begin nMismatched++; $display("FAIL s1_ready_flags: got %b want 10010", flags); end
  endtask

  // Valid drops after 30 settle cycles; later returns for a full settle.
  task automatic test_settle_drop();
    int n;
    applyReset();
    req_ibias_i = 1'b1; bg_valid_i = 1'b1;
    step();
    waitState(stWait, 40, n);
    nCompared++; if (n !== 16) begin nMismatched++; $display("FAIL s2_startup_len: got %0d want 16", n); end
    step();
    nCompared++; if (state_o !== stSettle) begin nMismatched++; $display("FAIL s2_immediate_settle: got %0d want %0d", state_o, stSettle); end
    for (int i = 2; i <= 28; i++) step();
    nCompared++; if (state_o !== stSettle) begin nMismatched++; $display("FAIL s2_settle28: got %0d want %0d", state_o, stSettle); end
    bg_valid_i = 1'b0;
    waitState(stWait, 10, n);
    nCompared++; if (n !== 3) begin nMismatched++; $display("FAIL s2_drop_latency: got %0d want 3", n); end
    // 1000 samples in WAIT_VALID: only safe if the timeout restarted.
    for (int i = 1; i < 1000; i++) step();
    nCompared++; if (state_o !== stWait) begin nMismatched++; $display("FAIL s2_timeout_restart: got %0d want %0d", state_o, stWait); end
    bg_valid_i = 1'b1;
    waitState(stSettle, 10, n);
    nCompared++; if (n !== 3) begin nMismatched++; $display("FAIL s2_resettle_latency: got %0d want 3", n); end
    waitState(stReady, 100, n);
    nCompared++; if (n !== 64) begin nMismatched++; $display("FAIL s2_full_resettle: got %0d want 64", n); end
  endtask

  // From READY: trim load restarts the settle window.
  task automatic test_trim_in_ready();
    int n;
    trim_ibias_i = 5'd3; trim_vbias_i = 4'd5; trim_load_i = 1'b1;
    step();
    trim_load_i = 1'b0;
    nCompared++; if (trim_ibias_o !== 5'd3 || trim_vbias_o !== 4'd5) begin nMismatched++; $display("FAIL s3_trim_update: got %0d/%0d want 3/5", trim_ibias_o, trim_vbias_o); end
    nCompared++; if (state_o !== stSettle || bias_ready_o !== 1'b0) begin nMismatched++; $display("FAIL s3_ready_drop: got state %0d ready %b want %0d/0", state_o, bias_ready_o, stSettle); end
    waitState(stReady, 100, n);
    nCompared++; if (n !== 64) begin nMismatched++; $display("FAIL s3_resettle: got %0d want 64", n); end
  endtask

  // From READY: requests drop on the same cycle the synced valid drops.
  task automatic test_off_not_error();
    bg_valid_i = 1'b0;
    step(); step();
    req_ibias_i = 1'b0; req_vbias_i = 1'b0;
    step();
    nCompared++; if (state_o !== stOff) begin nMismatched++; $display("FAIL s4_to_off: got %0d want %0d", state_o, stOff); end
    nCompared++; if (flags !== 5'b00000) begin nMismatched++; $display("FAIL s4_off_flags: got %b want 00000", flags); end
    for (int i = 0; i < 3; i++) step();
    nCompared++; if (state_o !== stOff || bias_err_o !== 1'b0) begin nMismatched++; $display("FAIL s4_stay_off: got state %0d err %b want 0/0", state_o, bias_err_o); end
  endtask

  // req_vbias only; valid never arrives.
  task automatic test_timeout_error();
    int n;
    applyReset();
    req_vbias_i = 1'b1;
    step();
    nCompared++; if (flags !== 5'b01100) begin nMismatched++; $display("FAIL s5_startup_flags: got %b want 01100", flags); end
    waitState(stWait, 40, n);
    nCompared++; if (n !== 16) begin nMismatched++; $display("FAIL s5_startup_len: got %0d want 16", n); end
    waitState(stError, 1100, n);
    nCompared++; if (n !== 1024) begin nMismatched++; $display("FAIL s5_timeout_len: got %0d want 1024", n); end
    nCompared++; if (flags !== 5'b00001) begin nMismatched++; $display("FAIL s5_error_flags: got %b want 00001", flags); end
    for (int i = 0; i < 5; i++) step();
    nCompared++; if (state_o !== stError || bias_err_o !== 1'b1) begin nMismatched++; $display("FAIL s5_sticky: got state %0d err %b want 5/1", state_o, bias_err_o); end
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    nCompared++; if (state_o !== stOff || bias_err_o !== 1'b0) begin nMismatched++; $display("FAIL s5_clear_off: got state %0d err %b want 0/0", state_o, bias_err_o); end
    step();
    nCompared++; if (state_o !== stStart || flags !== 5'b01100) begin nMismatched++; $display("FAIL s5_restart: got state %0d flags %b want 1/01100", state_o, flags); end
  endtask

  // Trim load in OFF, then reset asserted while in SETTLE.
  task automatic test_reset_in_settle();
    int n;
    applyReset();
    trim_ibias_i = 5'd1; trim_vbias_i = 4'd2; trim_load_i = 1'b1;
    step();
    trim_load_i = 1'b0;
    nCompared++; if (trim_ibias_o !== 5'd1 || trim_vbias_o !== 4'd2) begin nMismatched++; $display("FAIL s6_trim_off: got %0d/%0d want 1/2", trim_ibias_o, trim_vbias_o); end
    req_ibias_i = 1'b1; req_vbias_i = 1'b1; bg_valid_i = 1'b1;
    waitState(stSettle, 40, n);
    nCompared++; if (n !== 18) begin nMismatched++; $display("FAIL s6_reach_settle: got %0d want 18", n); end
    for (int i = 0; i < 10; i++) step();
    rst_ni = 1'b0;
    step();
    nCompared++; if (state_o !== stOff || flags !== 5'b00000) begin nMismatched++; $display("FAIL s6_reset_outputs: got state %0d flags %b want 0/00000", state_o, flags); end
    nCompared++; if (trim_ibias_o !== 5'd16 || trim_vbias_o !== 4'd8) begin nMismatched++; $display("FAIL s6_reset_trims: got %0d/%0d want 16/8", trim_ibias_o, trim_vbias_o); end
    rst_ni = 1'b1;
    step();
    nCompared++; if (state_o !== stStart || flags !== 5'b11100) begin nMismatched++; $display("FAIL s6_restart: got state %0d flags %b want 1/11100", state_o, flags); end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_ibias_startup();
    test_settle_drop();
    test_trim_in_ready();
    test_off_not_error();
    test_timeout_error();
    test_reset_in_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
